// File: rtl/alu_op_issuer_pkg.sv
// Shared definitions for the alu_op_issuer slice: data width, op encodings and FSM states.
package alu_op_issuer_pkg;

  localparam int unsigned DATA_W = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_OR  = 2'b10,
    OP_AND = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

endpackage

// File: rtl/alu_op_issuer_if.sv
// Command and response channels of alu_op_issuer; master issues commands, slave executes them.
interface alu_op_issuer_if;

  logic                                 cmd_valid;
  logic                                 cmd_ready;
  logic [1:0]                           cmd_op;
  logic [alu_op_issuer_pkg::DATA_W-1:0] cmd_a;
  logic [alu_op_issuer_pkg::DATA_W-1:0] cmd_b;
  logic                                 cmd_chain;
  logic                                 rsp_valid;
  logic                                 rsp_ready;
  logic [alu_op_issuer_pkg::DATA_W-1:0] rsp_q;
  logic                                 rsp_ovf;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_q, rsp_ovf
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain, rsp_ready,
    output cmd_ready, rsp_valid, rsp_q, rsp_ovf
  );

endinterface

// File: rtl/alu_op_issuer_alu4_core.sv
// Combinational 4-bit two's complement add/sub/OR/AND with signed overflow detection.
module alu4_core
  import alu_op_issuer_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  op_e               op,
  output logic [DATA_W-1:0] q,
  output logic              ovf
);

  always_comb begin
    q   = '0;
    ovf = 1'b0;
    unique case (op)
      OP_ADD: begin
        q   = a + b;
        ovf = (a[DATA_W-1] == b[DATA_W-1]) && (q[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SUB: begin
        q   = a - b;
        ovf = (a[DATA_W-1] != b[DATA_W-1]) && (q[DATA_W-1] != a[DATA_W-1]);
      end
      OP_OR:  q = a | b;
      OP_AND: q = a & b;
      default: begin
        q   = '0;
        ovf = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_op_issuer.sv
// Command front-end: accepts one op, evaluates it on alu4_core, holds the result until taken.
module alu_op_issuer
  import alu_op_issuer_pkg::*;
#(
  parameter int unsigned COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  alu_op_issuer_if.slave     bus,
  input  logic               clr_sticky,
  output logic [DATA_W-1:0]  acc,
  output logic               ovf_sticky,
  output logic [COUNT_W-1:0] op_count
);

  state_e            state, state_nxt;
  op_e               op_r;
  logic [DATA_W-1:0] a_r, b_r, q_r, core_q;
  logic              ovf_r, core_ovf;
  logic              accept, capture;

  assign accept  = (state == IDLE) && bus.cmd_valid;
  assign capture = (state == EXEC);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.cmd_valid) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Chained operand takes acc as it stands at the accept edge (last completed op).
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r <= OP_ADD;
      a_r  <= '0;
      b_r  <= '0;
    end else if (accept) begin
      op_r <= op_e'(bus.cmd_op);
      a_r  <= bus.cmd_chain ? acc : bus.cmd_a;
      b_r  <= bus.cmd_b;
    end
  end

  alu4_core u_core (
    .a   (a_r),
    .b   (b_r),
    .op  (op_r),
    .q   (core_q),
    .ovf (core_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      q_r        <= '0;
      ovf_r      <= 1'b0;
      acc        <= '0;
      op_count   <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      if (capture) begin
        q_r      <= core_q;
        ovf_r    <= core_ovf;
        acc      <= core_q;
        op_count <= op_count + COUNT_W'(1);
      end
      // A captured overflow takes priority over a simultaneous clear.
      if (capture && core_ovf) ovf_sticky <= 1'b1;
      else if (clr_sticky)     ovf_sticky <= 1'b0;
    end
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_q     = q_r;
  assign bus.rsp_ovf   = ovf_r;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Self-checking bench for alu_op_issuer: directed cases plus randomized traffic against a reference model.
module tb_alu_op_issuer;

  localparam int CW = 2;

  logic          clk;
  logic          rst;
  logic          clr_sticky;
  logic [3:0]    acc;
  logic          ovf_sticky;
  logic [CW-1:0] op_count;

  alu_op_issuer_if bus ();

  alu_op_issuer #(.COUNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .clr_sticky (clr_sticky),
    .acc        (acc),
    .ovf_sticky (ovf_sticky),
    .op_count   (op_count)
  );

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference arithmetic on signed integers; overflow means the true result leaves -8..7.
  function automatic void ref_alu(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                                  output logic [3:0] q, output logic ovf);
    int sa, sb, r;
    sa = $signed(a);
    sb = $signed(b);
    r  = 0;
    q  = 4'd0;
    ovf = 1'b0;
    case (op)
      2'b00: begin r = sa + sb; q = r[3:0]; ovf = (r > 7) || (r < -8); end
      2'b01: begin r = sa - sb; q = r[3:0]; ovf = (r > 7) || (r < -8); end
      2'b10: q = a | b;
      default: q = a & b;
    endcase
  endfunction

  // Model: one outstanding transaction, result visible one edge after accept, held until taken.
  logic       pend = 1'b0, outv = 1'b0;
  logic [3:0] pq = 4'd0, q_m = 4'd0, acc_m = 4'd0;
  logic       povf = 1'b0, ovf_m = 1'b0, stk_m = 1'b0, set_m = 1'b0;
  int         cnt_m = 0;

  always @(posedge clk) begin
    if (rst) begin
      pend = 1'b0; outv = 1'b0; q_m = 4'd0; ovf_m = 1'b0;
      acc_m = 4'd0; stk_m = 1'b0; cnt_m = 0;
    end else begin
      set_m = 1'b0;
      if (pend && !outv) begin
        outv  = 1'b1;
        q_m   = pq;
        ovf_m = povf;
        acc_m = pq;
        cnt_m = (cnt_m + 1) % (1 << CW);
        set_m = povf;
      end else if (outv && bus.rsp_ready) begin
        outv = 1'b0;
        pend = 1'b0;
      end else if (!pend && bus.cmd_valid) begin
        ref_alu(bus.cmd_op, bus.cmd_chain ? acc_m : bus.cmd_a, bus.cmd_b, pq, povf);
        pend = 1'b1;
      end
      if (set_m)           stk_m = 1'b1;
      else if (clr_sticky) stk_m = 1'b0;
    end
    #1;
    chk("m_cmd_ready", bus.cmd_ready, !pend);
    chk("m_rsp_valid", bus.rsp_valid, outv);
    if (outv) begin
      chk("m_rsp_q", bus.rsp_q, q_m);
      chk("m_rsp_ovf", bus.rsp_ovf, ovf_m);
    end
    chk("m_acc", acc, acc_m);
    chk("m_sticky", ovf_sticky, stk_m);
    chk("m_count", op_count, cnt_m);
  end

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_ready_timeout"}, int'(n < 20), 1);
  endtask

  // esticky < 0 skips the sticky check in the first response cycle.
  task automatic do_op(input string nm, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic chain, input logic [3:0] eq, input logic eovf, input int esticky);
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_a = a; bus.cmd_b = b;
    bus.cmd_chain = chain; bus.rsp_ready = 1'b0;
    wait_ready(nm);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk({nm, "_lat1_valid"}, bus.rsp_valid, 0);
    @(negedge clk);
    chk({nm, "_lat2_valid"}, bus.rsp_valid, 1);
    chk({nm, "_q"}, bus.rsp_q, eq);
    chk({nm, "_ovf"}, bus.rsp_ovf, eovf);
    if (esticky >= 0) chk({nm, "_sticky"}, ovf_sticky, esticky);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr_sticky = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_a = 4'd0; bus.cmd_b = 4'd0;
    bus.cmd_chain = 1'b0; bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_q", bus.rsp_q, 0);
    chk("rst_rsp_ovf", bus.rsp_ovf, 0);
    chk("rst_acc", acc, 0);
    chk("rst_sticky", ovf_sticky, 0);
    chk("rst_count", op_count, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    rst = 1'b0;

    do_op("add_7p1", 2'b00, 4'd7, 4'd1, 1'b0, 4'b1000, 1'b1, 1);
    do_op("add_m8m1", 2'b00, 4'b1000, 4'b1111, 1'b0, 4'd7, 1'b1, 1);
    @(negedge clk) clr_sticky = 1'b1;
    @(negedge clk) clr_sticky = 1'b0;
    chk("clr_sticky", ovf_sticky, 0);
    do_op("sub_0mm8", 2'b01, 4'd0, 4'b1000, 1'b0, 4'b1000, 1'b1, 1);
    do_op("sub_3m5", 2'b01, 4'd3, 4'd5, 1'b0, 4'b1110, 1'b0, 1);
    chk("acc_m2", acc, 4'b1110);
    chk("count_wrap4", op_count, 0);
    do_op("chain_or", 2'b10, 4'd3, 4'b0101, 1'b1, 4'b1111, 1'b0, -1);
    do_op("chain_and", 2'b11, 4'd0, 4'b0110, 1'b1, 4'd6, 1'b0, -1);

    // Backpressure with a second command waiting.
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'b00; bus.cmd_a = 4'd2; bus.cmd_b = 4'd3; bus.cmd_chain = 1'b0;
    wait_ready("bp");
    @(negedge clk);
    bus.cmd_op = 2'b01; bus.cmd_a = 4'd1; bus.cmd_b = 4'd1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", bus.rsp_valid, 1);
      chk("bp_q", bus.rsp_q, 5);
      chk("bp_cmd_ready", bus.cmd_ready, 0);
      chk("bp_count", op_count, 3);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("bp_idle_ready", bus.cmd_ready, 1);
    @(negedge clk);
    chk("bp_pending_taken", bus.cmd_ready, 0);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("bp2_valid", bus.rsp_valid, 1);
    chk("bp2_q", bus.rsp_q, 0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;

    // Set wins over a simultaneous clear.
    @(negedge clk) clr_sticky = 1'b1;
    do_op("set_wins", 2'b00, 4'd4, 4'd4, 1'b0, 4'b1000, 1'b1, 1);
    clr_sticky = 1'b0;
    chk("set_wins_after_clr", ovf_sticky, 0);

    // Reset while in EXEC abandons the command.
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'b00; bus.cmd_a = 4'd1; bus.cmd_b = 4'd1;
    wait_ready("mid_rst");
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_valid", bus.rsp_valid, 0);
    chk("mid_rst_count", op_count, 0);
    chk("mid_rst_acc", acc, 0);
    chk("mid_rst_ready", bus.cmd_ready, 1);
    @(negedge clk);
    chk("mid_rst_valid2", bus.rsp_valid, 0);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus.cmd_valid = ($urandom_range(0, 3) != 0);
      bus.cmd_op    = 2'($urandom_range(0, 3));
      bus.cmd_a     = 4'($urandom_range(0, 15));
      bus.cmd_b     = 4'($urandom_range(0, 15));
      bus.cmd_chain = ($urandom_range(0, 2) == 0);
      bus.rsp_ready = ($urandom_range(0, 2) != 0);
      clr_sticky    = ($urandom_range(0, 7) == 0);
      rst           = ($urandom_range(0, 149) == 0);
    end
    @(negedge clk);
    rst = 1'b0; bus.cmd_valid = 1'b0; bus.rsp_ready = 1'b1; clr_sticky = 1'b0;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
